// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window generator.
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int WIN_PIXELS = 9;
  localparam int WIN_W      = PIX_W * WIN_PIXELS;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} win_state_t;

  // One vertical slice of the 3x3 window: rows y-2 (top), y-1 (mid), y (bot).
  typedef struct packed {
    logic [PIX_W-1:0] top;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] bot;
  } column_t;

  // Packs three columns (x-2, x-1, x) into the Sobel image_buffer layout:
  // pixel_k sits at bits [8k-1:8k-8], row-major from the top-left.
  function automatic logic [WIN_W-1:0] pack_window(input column_t left,
                                                   input column_t centre,
                                                   input column_t right);
    return {right.bot, centre.bot, left.bot,
            right.mid, centre.mid, left.mid,
            right.top, centre.top, left.top};
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixels: combinational read, synchronous write at the same
// address, so a read in the write cycle returns the old contents.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter  int DEPTH = 640,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Store the incoming pixel for use by the next row.
  // NOTE: the array has no reset; stale rows are never used because windows
  // are only issued once two fresh rows of the current frame are stored.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream 3x3 window generator feeding the Sobel block.
// Pixel width comes from sobel_pkg::PIX_W (fixed at 8).
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int XW         = $clog2(IMG_WIDTH),
  localparam int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [WIN_W-1:0] image_buffer,
  output logic             win_valid,
  output logic [XW-1:0]    win_x,
  output logic [YW-1:0]    win_y,
  output logic             frame_done
);

  win_state_t       state;
  logic [XW-1:0]    x_cnt, cur_x;
  logic [YW-1:0]    y_cnt, cur_y;
  logic             accept, last_col, last_row;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  column_t          col_a, col_b, col_new;

  // Qualify the beat and resolve its raster position (sof forces (0,0)).
  // NOTE: every signal gets a value on every path here, so no latch is inferred.
  always_comb begin
    accept   = pix_valid && (state == FILL || state == STREAM || sof);
    cur_x    = sof ? '0 : x_cnt;
    cur_y    = sof ? '0 : y_cnt;
    last_col = (cur_x == XW'(IMG_WIDTH - 1));
    last_row = (cur_y == YW'(IMG_HEIGHT - 1));
    col_new  = {lb1_rd, lb0_rd, pix_in};
  end

  // lb0 holds row y-1; its old value cascades into lb1 (row y-2).
  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_x),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_x),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Frame FSM, raster counters, column shift array and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      x_cnt        <= '0;
      y_cnt        <= '0;
      col_a        <= '0;
      col_b        <= '0;
      image_buffer <= '0;
      win_valid    <= 1'b0;
      win_x        <= '0;
      win_y        <= '0;
      frame_done   <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        col_a <= col_b;
        col_b <= col_new;

        if (last_col) begin
          x_cnt <= '0;
          y_cnt <= last_row ? '0 : cur_y + YW'(1);
        end else begin
          x_cnt <= cur_x + XW'(1);
          y_cnt <= cur_y;
        end

        if (cur_x >= XW'(2) && cur_y >= YW'(2)) begin
          win_valid    <= 1'b1;
          image_buffer <= pack_window(col_a, col_b, col_new);
          win_x        <= cur_x - XW'(1);
          win_y        <= cur_y - YW'(1);
        end

        if (sof) begin
          state <= FILL;
        end else if (state == FILL && last_col && cur_y == YW'(1)) begin
          state <= STREAM;
        end else if (state == STREAM && last_col && last_row) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 image.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [71:0] image_buffer;
  logic        win_valid;
  logic [1:0]  win_x;
  logic [1:0]  win_y;
  logic        frame_done;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .sof          (sof),
    .image_buffer (image_buffer),
    .win_valid    (win_valid),
    .win_x        (win_x),
    .win_y        (win_y),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the current frame as a 2-D image plus a raster cursor.
  logic [7:0]  fr [H][W];
  bit          mdl_active = 0;
  int          mdl_px = 0;
  int          mdl_py = 0;
  logic        exp_valid = 1'b0;
  logic        exp_done = 1'b0;
  logic [71:0] exp_buf = '0;
  logic [1:0]  exp_x = '0;
  logic [1:0]  exp_y = '0;
  bit          chk_en = 0;

  int          cent_q[$];
  logic [71:0] buf_q[$];
  int          done_cnt = 0;
  logic [71:0] last_done_buf = '0;

  function automatic logic [71:0] window_at(input int px, input int py);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = fr[py-2+r][px-2+c];
    return w;
  endfunction

  // Drive one beat just after a falling edge and predict the outputs that
  // must appear after the following rising edge.
  task automatic step(input bit v, input bit s, input logic [7:0] p);
    @(negedge clk);
    #1;
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (v && (s || mdl_active)) begin
      if (s) begin
        mdl_active = 1;
        mdl_px = 0;
        mdl_py = 0;
      end
      fr[mdl_py][mdl_px] = p;
      if (mdl_px >= 2 && mdl_py >= 2) begin
        exp_valid = 1'b1;
        exp_buf   = window_at(mdl_px, mdl_py);
        exp_x     = 2'(mdl_px - 1);
        exp_y     = 2'(mdl_py - 1);
      end
      if (mdl_px == W-1 && mdl_py == H-1) begin
        exp_done   = 1'b1;
        mdl_active = 0;
      end
      mdl_px++;
      if (mdl_px == W) begin
        mdl_px = 0;
        mdl_py++;
        if (mdl_py == H) mdl_py = 0;
      end
    end
  endtask

  // mode 0: continuous pattern, 1: gap every other cycle, 2: random pixels,
  // random gaps and occasional mid-frame sof.
  task automatic send_frame(input int mode, input logic [7:0] base);
    int  guard;
    bit  v, s;
    logic [7:0] p;
    guard = 0;
    step(1, 1, base);
    while (mdl_active && guard < 400) begin
      guard++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : ($urandom_range(9) < 7);
      s = (mode == 2) && v && ($urandom_range(39) == 0);
      p = (mode == 2) ? 8'($urandom) : 8'(int'(base) + 16*mdl_py + mdl_px);
      step(v, s, p);
    end
    check("frame_bound", {71'd0, guard < 400}, 72'd1);
    step(0, 0, 8'h00);
  endtask

  task automatic clear_logs();
    cent_q.delete();
    buf_q.delete();
    done_cnt = 0;
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("win_valid",    {71'd0, win_valid},  {71'd0, exp_valid});
      check("frame_done",   {71'd0, frame_done}, {71'd0, exp_done});
      check("image_buffer", image_buffer,        exp_buf);
      check("win_x",        {70'd0, win_x},      {70'd0, exp_x});
      check("win_y",        {70'd0, win_y},      {70'd0, exp_y});
      if (win_valid) begin
        cent_q.push_back(int'(win_x) * 10 + int'(win_y));
        buf_q.push_back(image_buffer);
      end
      if (frame_done) begin
        done_cnt++;
        last_done_buf = image_buffer;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pix;

    // Reset state
    #2 n_rst = 1'b0;
    #1;
    check("rst_valid", {71'd0, win_valid},  72'd0);
    check("rst_done",  {71'd0, frame_done}, 72'd0);
    check("rst_buf",   image_buffer,        72'd0);
    check("rst_x",     {70'd0, win_x},      72'd0);
    check("rst_y",     {70'd0, win_y},      72'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 n_rst = 1'b1;
    chk_en = 1;

    // Frame A: pixel = 16*y + x, continuous
    clear_logs();
    for (int i = 0; i < W*H; i++) begin
      pix = 8'(16*(i/W) + i%W);
      step(1, i == 0, pix);
      if (pix == 8'h22) begin
        @(posedge clk);
        #1;
        check("no_early_win",    72'(cent_q.size()), 72'd0);
        check("first_win_valid", {71'd0, win_valid}, 72'd1);
        check("first_win_buf",   image_buffer, 72'h222120121110020100);
        check("first_win_x",     {70'd0, win_x}, 72'd1);
        check("first_win_y",     {70'd0, win_y}, 72'd1);
      end
    end
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    check("a_win_count", 72'(cent_q.size()), 72'd4);
    check("a_cent0", 72'(cent_q[0]), 72'd11);
    check("a_cent1", 72'(cent_q[1]), 72'd21);
    check("a_cent2", 72'(cent_q[2]), 72'd12);
    check("a_cent3", 72'(cent_q[3]), 72'd22);
    check("a_done_cnt", 72'(done_cnt), 72'd1);
    check("a_last_win", last_done_buf, 72'h333231232221131211);

    // Pixels in DONE without sof are dropped
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom));
    step(0, 0, 8'h00);
    check("done_drop_valid", {71'd0, win_valid}, 72'd0);
    check("done_drop_buf",   image_buffer, 72'h333231232221131211);
    check("done_drop_count", 72'(cent_q.size()), 72'd4);

    // Same frame with a gap every other cycle
    clear_logs();
    send_frame(1, 8'h00);
    check("gap_win_count", 72'(cent_q.size()), 72'd4);
    check("gap_cent0", 72'(cent_q[0]), 72'd11);
    check("gap_cent3", 72'(cent_q[3]), 72'd22);
    check("gap_first_buf", buf_q[0], 72'h222120121110020100);
    check("gap_done_cnt", 72'(done_cnt), 72'd1);
    check("gap_last_win", last_done_buf, 72'h333231232221131211);

    // Abort frame 1 with sof at (1,2), then full frame 2
    clear_logs();
    step(1, 1, 8'h00);
    while (!(mdl_px == 1 && mdl_py == 2)) step(1, 0, 8'(16*mdl_py + mdl_px));
    send_frame(0, 8'h80);
    check("abort_done_cnt",  72'(done_cnt), 72'd1);
    check("abort_win_count", 72'(buf_q.size()), 72'd4);
    check("f2_pixel1", {64'd0, buf_q[0][7:0]},   72'h80);
    check("f2_pixel9", {64'd0, buf_q[0][71:64]}, 72'hA2);
    check("f2_first_buf", buf_q[0], 72'hA2A1A0929190828180);

    // Randomised frames, with stray pixels between frames
    for (int f = 0; f < 12; f++) begin
      send_frame(2, 8'h00);
      repeat ($urandom_range(3)) step(1, 0, 8'($urandom));
    end

    // Asynchronous reset in the middle of STREAM
    step(1, 1, 8'($urandom));
    while (!(mdl_px == 0 && mdl_py == 3)) step(1, 0, 8'($urandom));
    @(posedge clk);
    #1;
    check("pre_reset_valid", {71'd0, win_valid}, 72'd1);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    n_rst     = 1'b0;
    mdl_active = 0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_buf   = '0;
    exp_x     = '0;
    exp_y     = '0;
    #1;
    check("mid_rst_valid", {71'd0, win_valid},  72'd0);
    check("mid_rst_done",  {71'd0, frame_done}, 72'd0);
    check("mid_rst_buf",   image_buffer,        72'd0);
    check("mid_rst_x",     {70'd0, win_x},      72'd0);
    check("mid_rst_y",     {70'd0, win_y},      72'd0);
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b1;
    clear_logs();
    for (int i = 0; i < 6; i++) step(1, 0, 8'($urandom));
    check("idle_no_win", 72'(cent_q.size()), 72'd0);
    send_frame(0, 8'h40);
    check("post_rst_first", buf_q[0], 72'h626160525150424140);
    check("post_rst_count", 72'(buf_q.size()), 72'd4);
    check("post_rst_done",  72'(done_cnt), 72'd1);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Raster-stream front end for the Sobel edge-detection path.
- Takes one 8-bit grayscale pixel per accepted beat, in row-major order from the SD-card image loader.
- Keeps two line buffers and a 3x3 column shift array, and emits one packed 72-bit window per interior pixel.
- Its outputs drive the image_buffer and enable inputs of the Sobel block directly.

Parameters:
- IMG_WIDTH, 640, pixels per row (minimum 3).
- IMG_HEIGHT, 480, rows per frame (minimum 3).
- PIX_W, 8, bits per pixel (fixed at 8 for this project).

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous reset, active-low
- pix_in  input  8  incoming pixel
- pix_valid  input  1  pix_in is valid this cycle (no backpressure)
- sof  input  1  start of frame; qualified by pix_valid, marks pixel (0,0)
- image_buffer  output  72  window; pixel_k at bits [8k-1:8k-8]
- win_valid  output  1  image_buffer valid; drives the Sobel enable input
- win_x  output  $clog2(IMG_WIDTH)  column of the window centre
- win_y  output  $clog2(IMG_HEIGHT)  row of the window centre
- frame_done  output  1  one-cycle pulse when the frame's last window is issued

Behaviour:
- Reset: state IDLE; image_buffer=0, win_valid=0, win_x=0, win_y=0, frame_done=0; column/row counters 0.
- Reset does not clear line-buffer contents. Stale data is masked by the validity rule.
- Window layout, row-major from the top-left:
  - pixel_1..3 = row y-2, columns x-2..x
  - pixel_4..6 = row y-1, columns x-2..x
  - pixel_7..9 = row y, columns x-2..x
- Accept = pix_valid && (state==FILL || state==STREAM || sof). Pixels in IDLE or DONE without sof are dropped.
- On accept at (x,y):
  - Read lb1[x] (row y-2) and lb0[x] (row y-1).
  - Write lb1[x] <= lb0[x] and lb0[x] <= pix_in, read-before-write in the same cycle.
  - Shift the column array left and load the new column {lb1[x], lb0[x], pix_in}.
- Counters: x increments per accept and wraps to 0 at IMG_WIDTH-1; y then increments.
- Latency: if the accepted pixel has x>=2 and y>=2, then on the next clock edge:
  - win_valid=1
  - image_buffer holds the new window
  - win_x=x-1, win_y=y-1
- Otherwise win_valid=0 on the next cycle. image_buffer holds its last value when win_valid=0.
- Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2). No border or padding windows are produced.
- FSM:
  - IDLE -> FILL on sof&&pix_valid; that pixel is taken as (0,0).
  - FILL (y<2) -> STREAM on the accept at (IMG_WIDTH-1, 1).
  - STREAM -> DONE on the accept at (IMG_WIDTH-1, IMG_HEIGHT-1). frame_done=1 in the same cycle as that final win_valid.
  - DONE -> FILL on sof&&pix_valid; otherwise stays in DONE and ignores pixels.
- sof mid-frame (FILL/STREAM): abort the current frame. The pixel is taken as (0,0) of a new frame, state goes to FILL, and no frame_done is issued.
- Gaps: pix_valid low freezes all state; win_valid is 0 the cycle after each gap cycle.
- Async reset mid-frame returns to IDLE immediately. A new sof is required.
- Arithmetic: counters are unsigned and never exceed dimension-1. No pixel arithmetic is done in this block.

Decomposition:
- Package sobel_pkg:
  - PIX_W=8, WIN_PIXELS=9, WIN_W=72
  - typedef win_state_t {IDLE, FILL, STREAM, DONE}
  - helper function pack_window (nine pixels -> 72 bits)
- Sub-module sobel_line_buffer: one IMG_WIDTH x 8 memory with read-before-write on a single address. Instantiated twice (lb0, lb1).

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pixel = 16*y+x, continuous pix_valid, sof on the first beat:
  - First win_valid occurs the cycle after pixel 0x22 is accepted.
  - image_buffer = {22,21,20,12,11,10,02,01,00} hex, MSB byte first.
  - win_x=1, win_y=1.
- Same frame continued:
  - Exactly 4 windows, centres (1,1),(2,1),(1,2),(2,2).
  - Last window pixel_9=0x33 with frame_done=1 in the same cycle.
- Same frame with pix_valid deasserted every other cycle:
  - Identical window sequence and values, each window one cycle after its completing pixel.
- sof re-asserted at pixel (1,2) of frame 1, then a full frame 2 with pixel = 0x80+16*y+x:
  - No frame_done for frame 1.
  - First frame-2 window pixel_1=0x80, pixel_9=0xA2.
- Pixels sent in DONE without sof:
  - win_valid stays 0, image_buffer unchanged.
  - A subsequent sof frame starts correctly.
- n_rst pulsed low mid-STREAM:
  - All outputs 0 asynchronously; no windows until the next sof.
  - The next frame's first window is correct despite stale line-buffer contents.
